// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: evaluates a branch condition against the {N,Z,V,C} flags,
// stalling decode while a flag write is in flight. Macro BR_ANNUL_EN enables delay-slot annulment.
module branch_resolve_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_valid,
  input  logic [3:0]  br_cond,
  input  logic        br_annul,
  input  logic [31:0] br_target,
  output logic        br_ack,
  input  logic        cc_we,
  input  logic [3:0]  cc_in,
  input  logic        cc_pending,
  output logic        stall,
  output logic        br_resolved,
  output logic        br_taken,
  output logic        pc_sel,
  output logic [31:0] pc_target,
  output logic        flush_ds,
  output logic [15:0] taken_cnt,
  input  logic        cnt_clr
);
  localparam int unsigned AW = 32;
  localparam int unsigned FW = 4;
  localparam int unsigned NW = 16;
  localparam logic [NW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, WAIT_CC, RESOLVE} state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] flags_q, flags_d;
  logic [FW-1:0] cond_q, cond_d;
  logic          annul_q, annul_d;
  logic [AW-1:0] tgt_q, tgt_d;
  logic [AW-1:0] pc_target_q, pc_target_d;
  logic [NW-1:0] taken_cnt_q, taken_cnt_d;

  logic cc_busy;
  logic eval;
  logic flush_c;

  assign cc_busy   = cc_pending | cc_we;
  assign taken_cnt = taken_cnt_q;

  // Condition evaluation on the flag value held at the start of the cycle
  always_comb begin
    logic n, z, v, c, l;
    n = flags_q[3];
    z = flags_q[2];
    v = flags_q[1];
    c = flags_q[0];
    l = n ^ v;
    eval = 1'b0;
    case (cond_q)
      4'h0: eval = 1'b0;
      4'h1: eval = 1'b1;
      4'h2: eval = z;
      4'h3: eval = ~z;
      4'h4: eval = l;
      4'h5: eval = ~l;
      4'h6: eval = l | z;
      4'h7: eval = ~l & ~z;
      4'h8: eval = n;
      4'h9: eval = ~n;
      4'hA: eval = v;
      4'hB: eval = ~v;
      4'hC: eval = c;
      4'hD: eval = ~c;
      4'hE: eval = c | z;
      4'hF: eval = ~(c | z);
      default: eval = 1'b0;
    endcase
  end

`ifdef BR_ANNUL_EN
  assign flush_c = annul_q & (~eval | (cond_q == 4'b0001));
`else
  logic unused_annul;
  assign unused_annul = annul_q;
  assign flush_c      = 1'b0;
`endif

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    flags_d     = cc_we ? cc_in : flags_q;
    cond_d      = cond_q;
    annul_d     = annul_q;
    tgt_d       = tgt_q;
    pc_target_d = pc_target_q;
    taken_cnt_d = taken_cnt_q;
    br_ack      = 1'b0;
    stall       = 1'b0;
    br_resolved = 1'b0;
    br_taken    = 1'b0;
    pc_sel      = 1'b0;
    flush_ds    = 1'b0;
    pc_target   = pc_target_q;

    case (state_q)
      IDLE: begin
        stall = br_valid & cc_busy;
        if (br_valid && !reset) begin
          br_ack  = 1'b1;
          cond_d  = br_cond;
          annul_d = br_annul;
          tgt_d   = br_target;
          state_d = cc_busy ? WAIT_CC : RESOLVE;
        end
      end
      WAIT_CC: begin
        stall = 1'b1;
        if (!cc_busy) state_d = RESOLVE;
      end
      RESOLVE: begin
        br_resolved = 1'b1;
        br_taken    = eval;
        pc_sel      = eval;
        flush_ds    = flush_c;
        pc_target   = tgt_q;
        pc_target_d = tgt_q;
        if (eval && (taken_cnt_q != CNT_MAX)) taken_cnt_d = taken_cnt_q + NW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (cnt_clr) taken_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      flags_q     <= '0;
      cond_q      <= '0;
      annul_q     <= 1'b0;
      tgt_q       <= '0;
      pc_target_q <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      cond_q      <= cond_d;
      annul_q     <= annul_d;
      tgt_q       <= tgt_d;
      pc_target_q <= pc_target_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: directed scenarios plus randomized branches
// against a flag/condition reference model. Honors BR_ANNUL_EN like the design.
module tb_branch_resolve_ctrl;
  logic        clk, reset;
  logic        br_valid, br_annul, br_ack;
  logic [3:0]  br_cond;
  logic [31:0] br_target;
  logic        cc_we, cc_pending;
  logic [3:0]  cc_in;
  logic        stall, br_resolved, br_taken, pc_sel, flush_ds, cnt_clr;
  logic [31:0] pc_target;
  logic [15:0] taken_cnt;

  branch_resolve_ctrl dut (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_cond(br_cond), .br_annul(br_annul),
    .br_target(br_target), .br_ack(br_ack), .cc_we(cc_we), .cc_in(cc_in),
    .cc_pending(cc_pending), .stall(stall), .br_resolved(br_resolved), .br_taken(br_taken),
    .pc_sel(pc_sel), .pc_target(pc_target), .flush_ds(flush_ds), .taken_cnt(taken_cnt),
    .cnt_clr(cnt_clr)
  );

  typedef struct packed {
    logic        taken;
    logic        flush;
    logic [31:0] tgt;
  } exp_t;

  exp_t        sb[$];
  int          errs = 0;
  int          checks = 0;
  logic [3:0]  flags_m = '0;
  logic [15:0] cnt_m = '0;
  logic [31:0] last_tgt = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Base predicates paired by cond[3:1]; odd codes are the complement of the even one
  function automatic logic model_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cf, l;
    logic [7:0] base;
    n = f[3]; z = f[2]; v = f[1]; cf = f[0];
    l = n ^ v;
    base = {cf | z, cf, v, n, l | z, l, z, 1'b0};
    return base[c[3:1]] ^ c[0];
  endfunction

  function automatic logic model_flush(input logic [3:0] c, input logic a, input logic tk);
`ifdef BR_ANNUL_EN
    return a & (~tk | (c == 4'd1));
`else
    return 1'b0 & a & tk & c[0];
`endif
  endfunction

  // Monitor: pops the scoreboard on every resolution, otherwise checks idle outputs
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (reset) last_tgt = '0;
    else if (br_resolved) begin
      if (sb.size() == 0) chk("unexpected_resolve", 32'(br_resolved), 32'd0);
      else begin
        e = sb.pop_front();
        chk("br_taken", 32'(br_taken), 32'(e.taken));
        chk("pc_sel", 32'(pc_sel), 32'(e.taken));
        chk("pc_target", pc_target, e.tgt);
        chk("flush_ds", 32'(flush_ds), 32'(e.flush));
        last_tgt = e.tgt;
      end
    end else begin
      chk("idle_outs", 32'({br_taken, pc_sel, flush_ds}), 32'd0);
      chk("pc_target_hold", pc_target, last_tgt);
    end
  end

  task automatic write_flags(input logic [3:0] v);
    cc_we = 1'b1; cc_in = v;
    @(negedge clk);
    flags_m = v; cc_we = 1'b0;
  endtask

  // One branch: b busy cycles (optional flag write in the last), then the RESOLVE cycle
  task automatic do_branch(input logic [3:0] c, input logic a, input logic [31:0] t, input int b,
                           input logic we, input logic [3:0] v, input logic we2,
                           input logic [3:0] v2, input logic clr);
    exp_t e;
    br_valid = 1'b1; br_cond = c; br_annul = a; br_target = t;
    cc_we = 1'b0; cc_pending = 1'b0; cnt_clr = 1'b0;
    if (b > 0) begin
      cc_we = (b == 1) && we; cc_pending = !cc_we; cc_in = v;
    end
    #1 chk("br_ack", 32'(br_ack), 32'd1);
    chk("stall_idle", 32'(stall), 32'(b > 0));
    @(negedge clk);
    if (cc_we) flags_m = cc_in;
    br_valid = 1'b0;
    for (int i = 1; i < b; i++) begin
      cc_we = (i == b - 1) && we; cc_pending = !cc_we; cc_in = v;
      #1 chk("stall_wait", 32'(stall), 32'd1);
      chk("resolved_wait", 32'(br_resolved), 32'd0);
      @(negedge clk);
      if (cc_we) flags_m = cc_in;
    end
    if (b > 0) begin
      cc_we = 1'b0; cc_pending = 1'b0;
      #1 chk("stall_wait_end", 32'(stall), 32'd1);
      chk("resolved_wait", 32'(br_resolved), 32'd0);
      @(negedge clk);
    end
    e.taken = model_eval(c, flags_m);
    e.flush = model_flush(c, a, e.taken);
    e.tgt = t;
    sb.push_back(e);
    cc_we = we2; cc_in = v2; cnt_clr = clr;
    br_valid = 1'($urandom_range(0, 1)); br_cond = ~c;
    #1 chk("resolved_latency", 32'(br_resolved), 32'd1);
    chk("ack_in_resolve", 32'(br_ack), 32'd0);
    chk("stall_resolve", 32'(stall), 32'd0);
    if (clr) cnt_m = '0;
    else if (e.taken && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
    @(negedge clk);
    if (we2) flags_m = v2;
    cc_we = 1'b0; cnt_clr = 1'b0; br_valid = 1'b0;
    #1 chk("taken_cnt", 32'(taken_cnt), 32'(cnt_m));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    reset = 1'b1; br_valid = 1'b0; br_cond = '0; br_annul = 1'b0; br_target = '0;
    cc_we = 1'b0; cc_in = '0; cc_pending = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 chk("rst_outs", 32'({br_ack, stall, br_resolved, br_taken, pc_sel, flush_ds}), 32'd0);
    chk("rst_pc_target", pc_target, 32'd0);
    chk("rst_taken_cnt", 32'(taken_cnt), 32'd0);
    @(negedge clk);

    // Z=1, cond=2, no stall
    write_flags(4'b0100);
    do_branch(4'd2, 1'b0, 32'h0000_1000, 0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    // Pending flag write, then N=1 evaluated with cond=4
    write_flags(4'b0000);
    do_branch(4'd4, 1'b0, 32'h0000_2000, 4, 1'b1, 4'b1000, 1'b0, 4'd0, 1'b0);
    // Annul cases
    do_branch(4'd0, 1'b1, 32'h0000_3000, 0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    do_branch(4'd1, 1'b1, 32'h0000_4000, 0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    write_flags(4'b0000);
    do_branch(4'd3, 1'b1, 32'h0000_5000, 0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    // Flag write during RESOLVE must not affect that evaluation
    write_flags(4'b0100);
    do_branch(4'd2, 1'b0, 32'h0000_6000, 0, 1'b0, 4'd0, 1'b1, 4'b0000, 1'b0);

    // Reset while in WAIT_CC discards the branch
    br_valid = 1'b1; br_cond = 4'd1; br_target = 32'hDEAD_0000; cc_pending = 1'b1;
    #1 chk("ack_pre_reset", 32'(br_ack), 32'd1);
    @(negedge clk);
    br_valid = 1'b0; reset = 1'b1;
    #1 chk("stall_wait_reset", 32'(stall), 32'd1);
    @(negedge clk);
    reset = 1'b0; cc_pending = 1'b0; flags_m = '0; cnt_m = '0;
    #1 chk("stall_after_reset", 32'(stall), 32'd0);
    chk("cnt_after_reset", 32'(taken_cnt), 32'd0);
    repeat (3) begin
      @(negedge clk);
      #1 chk("no_resolve_after_reset", 32'(br_resolved), 32'd0);
    end

    // Saturation and clear priority
    force dut.taken_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.taken_cnt_q;
    cnt_m = 16'hFFFE;
    #1 chk("cnt_preload", 32'(taken_cnt), 32'h0000_FFFE);
    repeat (3) do_branch(4'd1, 1'b0, 32'h0000_7000, 0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    do_branch(4'd1, 1'b0, 32'h0000_8000, 0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);

    // Randomized branches with idle-cycle flag writes and occasional clears
    for (int k = 0; k < 80; k++) begin
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        cc_we = 1'($urandom); cc_in = 4'($urandom); cnt_clr = ($urandom_range(0, 9) == 0);
        #1 chk("stall_gap", 32'(stall), 32'd0);
        chk("ack_gap", 32'(br_ack), 32'd0);
        @(negedge clk);
        if (cc_we) flags_m = cc_in;
        if (cnt_clr) cnt_m = '0;
        cc_we = 1'b0; cnt_clr = 1'b0;
      end
      do_branch(4'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 3)), 1'($urandom),
                4'($urandom), 1'($urandom), 4'($urandom), ($urandom_range(0, 15) == 0));
    end

    repeat (3) @(negedge clk);
    #3 chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
